// File: rtl/wire_stim_pkg.sv
// Shared state encoding, vector bit positions and sizing helper for the wire_use stimulus sequencer.
// Constants only; no latency and no flow control.
package wire_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IDX_A = 2;
  localparam int IDX_B = 1;
  localparam int IDX_D = 0;

  // A counter over n values needs at least one bit, even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wire_stim_hold_cnt.sv
// Counts the cycles a vector is held; last_o flags the final hold cycle and the count wraps to 0 after it.
// The flag is combinational from the count register; there is no backpressure, and clr_i has priority over en_i.
module wire_stim_hold_cnt
  import wire_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wire_stim_seq.sv
// Steps wire_use through PATTERN, holding each vector HOLD_CYCLES cycles, and records E_i at the end of each step.
// All outputs are registered; abort_i stops at once, while start_i is honoured only in IDLE.
module wire_stim_seq
  import wire_stim_pkg::*;
#(
  parameter int                     NUM_STEPS   = 7,
  parameter int                     HOLD_CYCLES = 5,
  parameter logic [3*NUM_STEPS-1:0] PATTERN     = 21'b001_011_010_111_110_100_000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         loop_i,
  input  logic                         abort_i,
  input  logic                         E_i,
  output logic                         A_o,
  output logic                         B_o,
  output logic                         D_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(NUM_STEPS)-1:0] step_o,
  output logic [NUM_STEPS-1:0]         result_o
);

  localparam int SW = $clog2(NUM_STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

  state_t                 state_q, state_d;
  logic [2:0]             vec_q, vec_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SW-1:0]          step_q, step_d;
  logic [NUM_STEPS-1:0]   result_q, result_d;
  logic                   hold_last;
  logic                   in_run;

  assign in_run = (state_q == ST_RUN);

  // Counter is held at zero outside RUN, so every pass and every restart begins at hold 0.
  wire_stim_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!in_run || abort_i),
    .en_i  (in_run),
    .last_o(hold_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (hold_last && (step_q == LAST_STEP) && !loop_i) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not driven below returns to zero.
  always_comb begin
    vec_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    step_d   = '0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          vec_d    = PATTERN[2:0];
          busy_d   = 1'b1;
          result_d = '0;
        end
      end
      ST_RUN: begin
        if (!abort_i) begin
          vec_d  = vec_q;
          busy_d = 1'b1;
          step_d = step_q;
          if (hold_last) begin
            result_d[step_q] = E_i;
            if (step_q != LAST_STEP) begin
              step_d = step_q + 1'b1;
              vec_d  = PATTERN[3*(int'(step_q) + 1) +: 3];
            end else if (loop_i) begin
              step_d = '0;
              vec_d  = PATTERN[2:0];
              done_d = 1'b1;
            end else begin
              vec_d  = '0;
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  assign A_o      = vec_q[IDX_A];
  assign B_o      = vec_q[IDX_B];
  assign D_o      = vec_q[IDX_D];
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign step_o   = step_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_wire_stim_seq.sv
// Directed bench: default sequencer with a selectable E_i return, plus a HOLD_CYCLES=1 instance fed from B_o.
module tb_wire_stim_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters; e_sel picks 0=A, 1=D, 2=B as the wire_use response.
  logic       rst, start, loop, abort;
  logic [1:0] e_sel;
  logic       a0, b0, d0, busy0, done0, e0;
  logic [2:0] step0;
  logic [6:0] res0;

  assign e0 = (e_sel == 2'd0) ? a0 : (e_sel == 2'd1) ? d0 : b0;

  wire_stim_seq dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .loop_i(loop), .abort_i(abort), .E_i(e0),
    .A_o(a0), .B_o(b0), .D_o(d0), .busy_o(busy0), .done_o(done0), .step_o(step0), .result_o(res0)
  );

  // Instance 1: one cycle per step, E_i = B_o.
  logic       start1;
  logic       a1, b1, d1, busy1, done1;
  logic [2:0] step1;
  logic [6:0] res1;

  wire_stim_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .loop_i(1'b0), .abort_i(1'b0), .E_i(b1),
    .A_o(a1), .B_o(b1), .D_o(d1), .busy_o(busy1), .done_o(done1), .step_o(step1), .result_o(res1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is asserted in the current cycle t; returns in cycle t+1.
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full non-looping pass of instance 0 from cycle t+1 through the IDLE cycle t+37.
  task automatic run_pass(input string tag, input logic [6:0] exp_res);
    kick();
    for (int c = 1; c <= 37; c++) begin
      chk({tag, "_busy"}, busy0, (c <= 35));
      chk({tag, "_done"}, done0, (c == 36));
      if (c == 1) chk({tag, "_res_clr"}, res0, 7'b0);
      if (c == 1) chk({tag, "_vec1"}, {a0, b0, d0}, 3'b000);
      if (c == 6) chk({tag, "_vec6"}, {a0, b0, d0}, 3'b100);
      if (c == 11) chk({tag, "_vec11"}, {a0, b0, d0}, 3'b110);
      if (c == 36) chk({tag, "_res"}, res0, exp_res);
      if (c == 37) chk({tag, "_idle"}, {a0, b0, d0, step0}, 6'b0);
      if (c < 37) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loop = 1'b0; abort = 1'b0; e_sel = 2'd0; start1 = 1'b0;
    tick();
    tick();
    chk("rst0", {a0, b0, d0, busy0, done0, step0, res0}, 32'b0);
    chk("rst1", {a1, b1, d1, busy1, done1, step1, res1}, 32'b0);
    rst = 1'b0;
    tick();
    chk("idle0", {a0, b0, d0, busy0, done0}, 5'b0);

    e_sel = 2'd0;
    run_pass("passA", 7'b0001110);
    e_sel = 2'd1;
    run_pass("passD", 7'b1101000);

    // Abort during step 2: back to IDLE with the two finished samples kept.
    e_sel = 2'd0;
    kick();
    for (int c = 1; c < 12; c++) tick();
    chk("ab_step", step0, 3'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_out", {a0, b0, d0, busy0, done0, step0}, 8'b0);
    chk("ab_res", res0, 7'b0000010);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ab_quiet", {busy0, done0}, 2'b0);
    end

    // Looping: two passes back to back, then release loop to end after the third.
    loop = 1'b1;
    kick();
    for (int c = 1; c <= 107; c++) begin
      chk("lp_done", done0, (c == 36 || c == 71 || c == 106));
      chk("lp_busy", busy0, (c <= 105));
      if (c == 36) chk("lp_restart", {a0, b0, d0, step0}, 6'b0);
      if (c == 36) chk("lp_res1", res0, 7'b0001110);
      if (c == 106) chk("lp_res3", res0, 7'b0001110);
      if (c == 71) loop = 1'b0;
      if (c < 107) tick();
    end

    // Reset mid pass, then a clean pass.
    kick();
    for (int c = 1; c < 20; c++) tick();
    chk("mr_partial", res0, 7'b0000110);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_clear", {a0, b0, d0, busy0, done0, step0, res0}, 32'b0);
    tick();
    chk("mr_idle", busy0, 1'b0);
    run_pass("post_rst", 7'b0001110);

    // HOLD_CYCLES=1 with start held high through RUN and DONE.
    start1 = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      chk("h1_busy", busy1, (c <= 7));
      chk("h1_done", done1, (c == 8));
      if (c == 3) chk("h1_vec3", {a1, b1, d1}, 3'b110);
      if (c == 8) chk("h1_res", res1, 7'b0111100);
      start1 = (c < 8);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wire_stim_seq.md
Name: wire_stim_seq

Overview:
- Upstream stimulus sequencer for the `wire_use` combinational block.
- Drives `wire_use` inputs A, B, D through a programmable sequence of 3-bit vectors, holding each vector for a fixed number of cycles.
- Samples the returned `wire_use` output E at the end of each step and reports a per-step response bitmap, giving a synthesizable self-test of the combinational stage.

Parameters:
- `NUM_STEPS`, 7: number of vectors in one pass; must be ≥2.
- `HOLD_CYCLES`, 5: cycles each vector is held; must be ≥1.
- `PATTERN`, 21'b001_011_010_111_110_100_000: packed vectors, 3*`NUM_STEPS` bits. Step k is `PATTERN[3k+2:3k]`; bit 2 = A, bit 1 = B, bit 0 = D.

Ports:
- `clk_i`  input  1  clock; all logic on rising edge.
- `rst_i`  input  1  synchronous reset, active-high.
- `start_i`  input  1  begin a pass; sampled only in IDLE.
- `loop_i`  input  1  sampled at end of each pass; 1 = restart at step 0.
- `abort_i`  input  1  stop immediately; return to IDLE.
- `E_i`  input  1  output of `wire_use`, fed back for sampling.
- `A_o`  output  1  drives `wire_use` A_i.
- `B_o`  output  1  drives `wire_use` B_i.
- `D_o`  output  1  drives `wire_use` D_i.
- `busy_o`  output  1  high while in RUN.
- `done_o`  output  1  one-cycle pulse after each completed pass.
- `step_o`  output  $clog2(`NUM_STEPS`)  current step index.
- `result_o`  output  `NUM_STEPS`  bit k = E_i sampled at end of step k.

Behaviour:
- Reset: state IDLE; `A_o`/`B_o`/`D_o`=0; `busy_o`=0; `done_o`=0; `step_o`=0; `result_o`=0; hold counter 0. `rst_i` overrides everything, including mid-pass.
- All outputs are registered; `E_i` is a combinational return of registered vectors and is sampled directly.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start_i`=1 → RUN next cycle: step=0, hold=0, vector=`PATTERN[2:0]`, `result_o` cleared, `busy_o`=1.
  - Otherwise vectors stay 0.
- RUN, per cycle:
  - `abort_i`=1 (highest priority after reset) → IDLE next cycle. Vectors go to 0, `busy_o`=0, no `done_o`, `result_o` keeps partial values, `step_o` goes to 0.
  - hold < `HOLD_CYCLES`-1 → hold++.
  - hold == `HOLD_CYCLES`-1 → `result_o[step]` <= `E_i`; hold <= 0. Then:
    - step < `NUM_STEPS`-1: step++ and load the next vector.
    - Last step, `loop_i`=1: step=0, vector=`PATTERN[2:0]`, stay RUN, `done_o`=1 next cycle. `result_o` is not cleared; bits are overwritten step by step.
    - Last step, `loop_i`=0: → DONE.
- DONE: one cycle. `done_o`=1, `busy_o`=0, vectors 0, `step_o`=0. Always → IDLE; `start_i` is ignored here.
- `start_i` in RUN or DONE: ignored.
- Simultaneous `abort_i` and last-step sample: abort wins; the sample is discarded.
- Timing (start sampled at cycle t): step k is driven on cycles t+1+k*H .. t+(k+1)*H, where H=`HOLD_CYCLES`. Single pass: DONE (`done_o`=1) at t+1+`NUM_STEPS`*H; IDLE the following cycle. Earliest restart: `start_i` in that IDLE cycle.
- `HOLD_CYCLES`=1: one cycle per step; sample on the same cycle the vector is driven.

Decomposition:
- Package `wire_stim_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2); vector bit-index constants (IDX_A=2, IDX_B=1, IDX_D=0).
- Sub-module `wire_stim_hold_cnt`: hold counter with clear and `last_o` flag. Parameter `HOLD_CYCLES`; ports `clk_i`, `rst_i`, `clr_i`, `en_i`, `last_o`.
- Top instantiates one `wire_stim_hold_cnt` plus the FSM, step counter and result register.

Test Plan:
- Defaults, `E_i` tied to `A_o`, start pulse at t, `loop_i`=0 → `result_o`=7'b0001110, `done_o` high only at t+36, `busy_o` high t+1..t+35.
- Defaults, `E_i` tied to `D_o` → `result_o`=7'b1101000. Check {A,B,D} at t+1, t+6, t+11 equals 000, 100, 110.
- `abort_i` pulsed at t+12 (step 2) → IDLE at t+13, vectors 0, no `done_o`, `result_o`=7'b0000010 (`E_i`=`A_o`).
- `loop_i`=1 throughout → `done_o` pulses at t+36 and t+71, `busy_o` stays 1, step 0 re-driven at t+36. Then `loop_i`=0 → DONE after the next pass.
- `rst_i` asserted at t+20 → next cycle all outputs 0, state IDLE. `start_i` after release begins a clean pass with `result_o` cleared.
- `HOLD_CYCLES`=1, `E_i`=`B_o` → `done_o` at t+8, `result_o`=7'b0111100. `start_i` asserted during RUN/DONE is ignored.
